// File: rtl/pipeline_hazard_unit.sv
// Purpose: pipeline freeze/bubble/squash control for the four pipe registers and the PC.
// Latency: control outputs are combinational from state and inputs; state and counters update on CLK.
// Backpressure: a data-cache miss freezes everything up to MEM and feeds bubbles into WB until dhit.
//
// Ports:
//   CLK, RST                  core clock, synchronous active-high reset
//   ihit, dhit                fetch / data access completes this cycle
//   ifid_rs, ifid_rt,
//   ifid_uses_rt              source operands of the instruction in ID
//   idex_dREN, idex_wsel      load flag and destination of the instruction in EX
//   exmem_dREN, exmem_dWEN    memory access of the instruction in MEM
//   ex_redirect               taken branch/jump resolved in EX
//   memwb_halt                halt instruction reached WB
//   pcEN, *_EN, *_flush       PC and pipe register controls
//   halted                    sticky halt indication
//   stall_cnt, flush_cnt      performance counters (built only with HAZARD_PERF_CNT_EN)
//
// Macro HAZARD_PERF_CNT_EN: when defined, the saturating stall/flush counters are
// built; otherwise both counter outputs are tied to zero and no counter flops exist.

module pipeline_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_wsel,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             ex_redirect,
    input  logic             memwb_halt,
    output logic             pcEN,
    output logic             ifid_EN,
    output logic             ifid_flush,
    output logic             idex_EN,
    output logic             idex_flush,
    output logic             exmem_EN,
    output logic             exmem_flush,
    output logic             memwb_EN,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;

    logic dmem;
    logic dstall;
    logic luse;
    logic redirect_take;

    assign dmem   = exmem_dREN | exmem_dWEN;
    assign dstall = dmem & ~dhit;

    // A load writing $zero never creates a dependency; rt only matters when it is read.
    assign luse = idex_dREN && (idex_wsel != 5'd0) &&
                  ((idex_wsel == ifid_rs) || (ifid_uses_rt && (idex_wsel == ifid_rt)));

    assign halted = (state == HALT);

    // State register: HALT is absorbing until reset and wins over a concurrent miss.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            case (state)
                RUN, DWAIT: begin
                    if (memwb_halt)  state <= HALT;
                    else if (dstall) state <= DWAIT;
                    else             state <= RUN;
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        pcEN          = 1'b1;
        ifid_EN       = 1'b1;
        ifid_flush    = 1'b0;
        idex_EN       = 1'b1;
        idex_flush    = 1'b0;
        exmem_EN      = 1'b1;
        exmem_flush   = 1'b0;
        memwb_EN      = 1'b1;
        memwb_flush   = 1'b0;
        redirect_take = 1'b0;

        if (state == HALT) begin
            pcEN        = 1'b0;
            ifid_EN     = 1'b0;
            idex_EN     = 1'b0;
            exmem_EN    = 1'b0;
            memwb_EN    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (dstall) begin
            // Freeze up to MEM; redirect and load-use wait until the access completes.
            pcEN        = 1'b0;
            ifid_EN     = 1'b0;
            idex_EN     = 1'b0;
            exmem_EN    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            // Squash the two younger instructions; any outstanding fetch is abandoned.
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            redirect_take = 1'b1;
        end else if (luse) begin
            // Hold PC and IF/ID, push one bubble into EX.
            pcEN       = 1'b0;
            ifid_EN    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            // Fetch not done: keep PC, feed a bubble into ID, let the rest drain.
            pcEN       = 1'b0;
            ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic stall_inc;

    assign stall_inc = ~pcEN & (state != HALT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect_take && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
